msrv32_lsu: RTL and testbench
=============================

// Module: msrv32_lsu
// PURPOSE
//  Load/store unit downstream of the msrv32 instruction decoder. Consumes the decoder's memory-request,
//  load-size/unsigned and misaligned flags plus the integer-adder address, and runs one data-bus
//  transaction per access (req/ack handshake with timeout). Produces aligned, sign/zero-extended load
//  data, byte-lane store strobes, a pipeline stall while an access is in flight, and an access-fault pulse.
// PARAMETERS
//  XLEN         32   data/address width (only 32 supported)
//  TIMEOUT_CYC  255  max cycles in BUSY without ack before fault; counter width $clog2(TIMEOUT_CYC+1)
// PORTS
//  ms_riscv32_mp_clk_in    in   1     single clock, rising edge
//  ms_riscv32_mp_rst_n_in  in   1     asynchronous, active-low reset
//  ld_req_in               in   1     load instruction in decode this cycle
//  st_req_in               in   1     store instruction (decoder mem_wr_req)
//  size_in                 in   2     00 byte, 01 half, 10 word (11 treated as word)
//  unsigned_in             in   1     zero-extend load (LBU/LHU)
//  addr_in                 in   XLEN  effective address (iadder result)
//  wdata_in                in   XLEN  store data (rs2)
//  misaligned_ld_in        in   1     decoder misaligned-load flag
//  misaligned_st_in        in   1     decoder misaligned-store flag
//  trap_taken_in           in   1     trap this cycle: do not accept; kill in-flight load result
//  dbus_req_out            out  1     bus request, held until ack/err/timeout
//  dbus_we_out             out  1     1 = write
//  dbus_addr_out           out  XLEN  word-aligned address ({addr[31:2],2'b00})
//  dbus_wdata_out          out  XLEN  lane-replicated store data
//  dbus_mask_out           out  4     byte strobes
//  dbus_ack_in             in   1     transaction complete
//  dbus_err_in             in   1     bus error, qualified by dbus_ack_in
//  dbus_rdata_in           in   XLEN  read data, valid with ack
//  lsu_stall_out           out  1     freeze upstream pipeline
//  load_data_out           out  XLEN  aligned/extended load result
//  load_valid_out          out  1     1-cycle write-back strobe for load_data_out
//  access_fault_out        out  1     1-cycle pulse: bus error or timeout
// BEHAVIOUR
//  Reset (async, any state): state IDLE; all outputs 0; timeout counter and kill flag 0.
//  FSM IDLE -> BUSY -> DONE -> IDLE.
//  IDLE: accept = (ld_req_in|st_req_in) & ~misaligned flag for that access & ~trap_taken_in.
//   On accept register address, lane data, mask and we; go BUSY. lsu_stall_out = accept (combinational).
//   Misaligned or trapped requests: no bus activity, no stall, stay IDLE (trap unit owns them).
//   ld and st both high: store wins (decoder never does this; bench asserts it).
//  BUSY: dbus_req_out=1; addr/wdata/mask/we held stable every cycle; stall=1; counter increments.
//   ack & ~err -> DONE; ack & err -> DONE with fault; counter==TIMEOUT_CYC -> DONE with fault,
//   req dropped. trap_taken_in while BUSY sets kill; bus transaction still completes.
//  DONE (1 cycle): req=0, stall=0. Load: load_valid_out=1 with data registered at ack, unless kill
//   or fault. access_fault_out=1 if fault (regardless of kill). Clear kill and counter; go IDLE.
//  Latency: accepted access stalls >=2 cycles (accept + BUSY); zero-wait ack gives result in cycle 3.
//  Store lanes: SB mask 0001<<a[1:0], data {4{b}}; SH mask 0011<<{a[1],1'b0}, data {2{h}}; SW 1111.
//  Load extract: byte = rdata>>(8*a[1:0]); half = a[1] ? rdata[31:16] : rdata[15:0];
//   sign-extend from bit 7/15 unless unsigned_in; word passes through.
//  Load outputs hold last value when load_valid_out=0.
// STRUCTURE
//  msrv32_pkg: LSU state encodings, size codes (SZ_B/H/W), TIMEOUT default.
//  Sub-module msrv32_load_align: combinational lane select + sign/zero extend (rdata, a[1:0], size,
//   unsigned -> data). FSM, counter and bus registers live in msrv32_lsu.
// TESTING
//  1. LW addr 0x100, ack next BUSY cycle, rdata 0xDEADBEEF -> dbus_addr 0x100, mask 1111, stall 2 cyc,
//     load_valid with 0xDEADBEEF.
//  2. LB addr 0x103, rdata 0x80112233 -> 0xFFFFFF80; LBU same -> 0x00000080; LH addr 0x102 -> 0xFFFF8011.
//  3. SB addr 0x201 wdata 0xA5 -> we=1, mask 0010, wdata 0xA5A5A5A5; SH addr 0x202 -> mask 1100.
//  4. LW with misaligned_ld_in=1 -> no dbus_req, no stall; ack withheld TIMEOUT_CYC cycles -> fault
//     pulse, no load_valid.
//  5. trap_taken_in mid-BUSY on load, ack 3 cycles later -> req held until ack, load_valid stays 0.
//  6. Reset asserted mid-BUSY -> dbus_req_out and stall drop immediately; next access starts clean.

Source files
------------

// File: rtl/msrv32_pkg.sv
// Shared definitions for the msrv32 load/store unit.
//  - lsu_state_e : LSU transaction state encodings
//  - SZ_B/SZ_H/SZ_W : decoder access-size codes (2'b11 is treated as word)
//  - LSU_TIMEOUT_DEFAULT : default bus timeout in BUSY cycles
//  - store_mask / store_lanes : byte-strobe and lane-replication helpers
package msrv32_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_BUSY = 2'b01,
        LSU_DONE = 2'b10
    } lsu_state_e;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam int LSU_TIMEOUT_DEFAULT = 255;

    // Byte strobes for an access of the given size at byte offset off.
    function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] mask;
        case (size)
            SZ_B:    mask = 4'b0001 << off;
            SZ_H:    mask = 4'b0011 << {off[1], 1'b0};
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

    // Replicate the low byte/half of wdata across every lane so the strobes select it.
    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] lanes;
        case (size)
            SZ_B:    lanes = {4{wdata[7:0]}};
            SZ_H:    lanes = {2{wdata[15:0]}};
            default: lanes = wdata;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/msrv32_load_align.sv
// Load data aligner: selects the addressed byte/half from a 32-bit bus word
// and sign- or zero-extends it; words pass through unchanged.
//  rdata_in    : raw bus read data
//  offset_in   : address bits [1:0] of the access
//  size_in     : SZ_B / SZ_H / SZ_W (2'b11 treated as word)
//  unsigned_in : 1 = zero-extend, 0 = sign-extend
//  data_out    : aligned, extended load value
module msrv32_load_align
    import msrv32_pkg::*;
(
    input  logic [31:0] rdata_in,
    input  logic [1:0]  offset_in,
    input  logic [1:0]  size_in,
    input  logic        unsigned_in,
    output logic [31:0] data_out
);

    logic [31:0] shifted_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane select then extension by access size.
    always_comb begin
        shifted_s = rdata_in >> {offset_in, 3'b000};
        byte_s    = shifted_s[7:0];
        if (offset_in[1]) begin
            half_s = rdata_in[31:16];
        end else begin
            half_s = rdata_in[15:0];
        end
        case (size_in)
            SZ_B: begin
                if (unsigned_in) begin
                    data_out = {24'h000000, byte_s};
                end else begin
                    data_out = {{24{byte_s[7]}}, byte_s};
                end
            end
            SZ_H: begin
                if (unsigned_in) begin
                    data_out = {16'h0000, half_s};
                end else begin
                    data_out = {{16{half_s[15]}}, half_s};
                end
            end
            default: data_out = rdata_in;
        endcase
    end

endmodule

// File: rtl/msrv32_lsu.sv
// msrv32 load/store unit. Accepts one memory access per instruction from the
// decoder, runs a single req/ack data-bus transaction (with timeout) and
// returns aligned load data, a pipeline stall and an access-fault pulse.
//  Decoder side : ld_req_in, st_req_in, size_in, unsigned_in, addr_in, wdata_in,
//                 misaligned_ld_in, misaligned_st_in, trap_taken_in
//  Data bus     : dbus_req_out, dbus_we_out, dbus_addr_out, dbus_wdata_out,
//                 dbus_mask_out, dbus_ack_in, dbus_err_in, dbus_rdata_in
//  Pipeline     : lsu_stall_out (combinational), load_data_out, load_valid_out,
//                 access_fault_out
module msrv32_lsu
    import msrv32_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int TIMEOUT_CYC = LSU_TIMEOUT_DEFAULT
) (
    input  logic            ms_riscv32_mp_clk_in,
    input  logic            ms_riscv32_mp_rst_n_in,
    input  logic            ld_req_in,
    input  logic            st_req_in,
    input  logic [1:0]      size_in,
    input  logic            unsigned_in,
    input  logic [XLEN-1:0] addr_in,
    input  logic [XLEN-1:0] wdata_in,
    input  logic            misaligned_ld_in,
    input  logic            misaligned_st_in,
    input  logic            trap_taken_in,
    output logic            dbus_req_out,
    output logic            dbus_we_out,
    output logic [XLEN-1:0] dbus_addr_out,
    output logic [XLEN-1:0] dbus_wdata_out,
    output logic [3:0]      dbus_mask_out,
    input  logic            dbus_ack_in,
    input  logic            dbus_err_in,
    input  logic [XLEN-1:0] dbus_rdata_in,
    output logic            lsu_stall_out,
    output logic [XLEN-1:0] load_data_out,
    output logic            load_valid_out,
    output logic            access_fault_out
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    lsu_state_e      state_r;
    lsu_state_e      state_next_s;

    logic            req_ok_s;
    logic            accept_s;
    logic            stall_s;
    logic            busy_s;
    logic            timeout_s;
    logic            finish_s;
    logic            fault_s;
    logic            kill_now_s;
    logic            ld_ok_s;
    logic [3:0]      lane_mask_s;
    logic [XLEN-1:0] lane_wdata_s;
    logic [XLEN-1:0] align_data_s;

    logic [CNT_W-1:0] cnt_r;
    logic             kill_r;
    logic             req_r;
    logic             we_r;
    logic [XLEN-1:0]  addr_r;
    logic [XLEN-1:0]  wdata_r;
    logic [3:0]       mask_r;
    logic [1:0]       size_r;
    logic [1:0]       offset_r;
    logic             unsigned_r;
    logic [XLEN-1:0]  load_data_r;
    logic             load_valid_r;
    logic             fault_r;

    // Request qualification: a store takes priority and uses its own misaligned flag.
    // Gated with reset so no stall is reported while the unit is held in reset.
    always_comb begin
        if (st_req_in) begin
            req_ok_s = ~misaligned_st_in;
        end else begin
            req_ok_s = ld_req_in & ~misaligned_ld_in;
        end
        accept_s = req_ok_s & ~trap_taken_in & ms_riscv32_mp_rst_n_in & (state_r == LSU_IDLE);
    end

    // Completion conditions while the bus transaction is outstanding.
    // An ack in the final counted cycle wins over the timeout.
    always_comb begin
        busy_s     = (state_r == LSU_BUSY);
        timeout_s  = busy_s & ~dbus_ack_in & (cnt_r == CNT_W'(TIMEOUT_CYC));
        finish_s   = busy_s & (dbus_ack_in | timeout_s);
        fault_s    = (dbus_ack_in & dbus_err_in) | timeout_s;
        // A trap in the completing cycle still kills the load result.
        kill_now_s = kill_r | trap_taken_in;
        ld_ok_s    = finish_s & ~we_r & ~kill_now_s & ~fault_s;
    end

    // Store lane shaping from the live request; loads carry no write data.
    always_comb begin
        lane_mask_s = store_mask(size_in, addr_in[1:0]);
        if (st_req_in) begin
            lane_wdata_s = store_lanes(size_in, wdata_in);
        end else begin
            lane_wdata_s = {XLEN{1'b0}};
        end
    end

    // FSM state register.
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            state_r <= LSU_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            LSU_IDLE: begin
                if (accept_s) begin
                    state_next_s = LSU_BUSY;
                end else begin
                    state_next_s = LSU_IDLE;
                end
            end
            LSU_BUSY: begin
                if (finish_s) begin
                    state_next_s = LSU_DONE;
                end else begin
                    state_next_s = LSU_BUSY;
                end
            end
            LSU_DONE: state_next_s = LSU_IDLE;
            default:  state_next_s = LSU_IDLE;
        endcase
    end

    // FSM outputs: stall covers the accept cycle and every BUSY cycle.
    always_comb begin
        stall_s = 1'b0;
        case (state_r)
            LSU_IDLE: stall_s = accept_s;
            LSU_BUSY: stall_s = 1'b1;
            LSU_DONE: stall_s = 1'b0;
            default:  stall_s = 1'b0;
        endcase
    end

    // Bus request registers: captured on accept and held stable until completion.
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            req_r      <= 1'b0;
            we_r       <= 1'b0;
            addr_r     <= {XLEN{1'b0}};
            wdata_r    <= {XLEN{1'b0}};
            mask_r     <= 4'b0000;
            size_r     <= 2'b00;
            offset_r   <= 2'b00;
            unsigned_r <= 1'b0;
        end else if (accept_s) begin
            req_r      <= 1'b1;
            we_r       <= st_req_in;
            addr_r     <= {addr_in[XLEN-1:2], 2'b00};
            wdata_r    <= lane_wdata_s;
            mask_r     <= lane_mask_s;
            size_r     <= size_in;
            offset_r   <= addr_in[1:0];
            unsigned_r <= unsigned_in;
        end else if (finish_s) begin
            req_r      <= 1'b0;
        end
    end

    // Timeout counter and kill flag, both live only within a transaction.
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            cnt_r  <= {CNT_W{1'b0}};
            kill_r <= 1'b0;
        end else if (busy_s && !finish_s) begin
            cnt_r  <= cnt_r + CNT_W'(1);
            kill_r <= kill_now_s;
        end else begin
            cnt_r  <= {CNT_W{1'b0}};
            kill_r <= 1'b0;
        end
    end

    msrv32_load_align u_load_align (
        .rdata_in    (dbus_rdata_in),
        .offset_in   (offset_r),
        .size_in     (size_r),
        .unsigned_in (unsigned_r),
        .data_out    (align_data_s)
    );

    // Result registers: one-cycle strobes in DONE; load data holds otherwise.
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            load_data_r  <= {XLEN{1'b0}};
            load_valid_r <= 1'b0;
            fault_r      <= 1'b0;
        end else begin
            load_valid_r <= ld_ok_s;
            fault_r      <= finish_s & fault_s;
            if (ld_ok_s) begin
                load_data_r <= align_data_s;
            end
        end
    end

    assign dbus_req_out     = req_r;
    assign dbus_we_out      = we_r;
    assign dbus_addr_out    = addr_r;
    assign dbus_wdata_out   = wdata_r;
    assign dbus_mask_out    = mask_r;
    assign lsu_stall_out    = stall_s;
    assign load_data_out    = load_data_r;
    assign load_valid_out   = load_valid_r;
    assign access_fault_out = fault_r;

endmodule

// File: tb/tb_msrv32_lsu.sv
// Scoreboard bench for msrv32_lsu: the stimulus task pushes expected bus
// transactions and load/fault results; a bus responder and a result monitor
// pop and compare independently.
module tb_msrv32_lsu;

    localparam int TMO = 255;

    logic        clk;
    logic        rst_n;
    logic        ld_req, st_req, uns, mis_ld, mis_st, trap;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        dbus_req, dbus_we, dbus_ack, dbus_err;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
    logic [3:0]  dbus_mask;
    logic        stall, load_valid, fault;
    logic [31:0] load_data;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] wdata;
        int          delay;
        logic        err;
        logic [31:0] rdata;
    } bus_t;

    typedef struct {
        logic        fault;
        logic [31:0] data;
    } res_t;

    bus_t bus_q[$];
    res_t res_q[$];

    msrv32_lsu #(.XLEN(32), .TIMEOUT_CYC(TMO)) dut (
        .ms_riscv32_mp_clk_in   (clk),
        .ms_riscv32_mp_rst_n_in (rst_n),
        .ld_req_in              (ld_req),
        .st_req_in              (st_req),
        .size_in                (size),
        .unsigned_in            (uns),
        .addr_in                (addr),
        .wdata_in               (wdata),
        .misaligned_ld_in       (mis_ld),
        .misaligned_st_in       (mis_st),
        .trap_taken_in          (trap),
        .dbus_req_out           (dbus_req),
        .dbus_we_out            (dbus_we),
        .dbus_addr_out          (dbus_addr),
        .dbus_wdata_out         (dbus_wdata),
        .dbus_mask_out          (dbus_mask),
        .dbus_ack_in            (dbus_ack),
        .dbus_err_in            (dbus_err),
        .dbus_rdata_in          (dbus_rdata),
        .lsu_stall_out          (stall),
        .load_data_out          (load_data),
        .load_valid_out         (load_valid),
        .access_fault_out       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model, written from the access rules with plain arithmetic.
    function automatic logic [31:0] model_load(input logic [31:0] rd, input int off,
                                               input int sz, input bit unsg);
        longint x;
        if (sz == 0) begin
            x = longint'((rd >> (8 * off)) & 32'hFF);
            if (!unsg && x >= 128) x = x - 256;
        end else if (sz == 1) begin
            x = longint'((rd >> (16 * (off / 2))) & 32'hFFFF);
            if (!unsg && x >= 32768) x = x - 65536;
        end else begin
            x = longint'(rd);
        end
        return x[31:0];
    endfunction

    function automatic logic [3:0] model_mask(input int off, input int sz);
        int m;
        if (sz == 0)      m = 1 << off;
        else if (sz == 1) m = 3 << ((off / 2) * 2);
        else              m = 15;
        return m[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] wd, input int sz);
        if (sz == 0)      return (wd & 32'hFF) * 32'h01010101;
        else if (sz == 1) return (wd & 32'hFFFF) * 32'h00010001;
        else              return wd;
    endfunction

    // One decoder request. trap_busy / rst_busy select a BUSY-cycle index (-1 = none).
    task automatic issue(input bit l, input bit s, input int sz, input bit u,
                         input logic [31:0] a, input logic [31:0] wd,
                         input bit ml, input bit ms, input bit trap_acc,
                         input int delay, input bit err, input logic [31:0] rd,
                         input int trap_busy, input int rst_busy);
        bit   acc;
        bit   tmo;
        int   off;
        int   stall_cnt;
        int   exp_stall;
        int   cyc;
        bus_t b;
        res_t r;
        off = int'(a & 32'h3);
        acc = !trap_acc && (s ? !ms : (l && !ml));
        tmo = (delay > TMO);
        if (acc) begin
            b.we    = s;
            b.addr  = a & 32'hFFFF_FFFC;
            b.mask  = model_mask(off, sz);
            b.wdata = model_wdata(wd, sz);
            b.delay = delay;
            b.err   = err;
            b.rdata = rd;
            bus_q.push_back(b);
            if (rst_busy < 0) begin
                if (tmo || err) begin
                    r.fault = 1'b1;
                    r.data  = 32'h0;
                    res_q.push_back(r);
                end else if (!s && trap_busy < 0) begin
                    r.fault = 1'b0;
                    r.data  = model_load(rd, off, sz, u);
                    res_q.push_back(r);
                end
            end
        end
        @(negedge clk);
        ld_req = l; st_req = s; size = sz[1:0]; uns = u; addr = a; wdata = wd;
        mis_ld = ml; mis_st = ms; trap = trap_acc;
        #1;
        chk("stall_on_request", {31'b0, stall}, {31'b0, acc});
        stall_cnt = stall ? 1 : 0;
        @(negedge clk);
        ld_req = 0; st_req = 0; mis_ld = 0; mis_st = 0; trap = 0;
        addr = $urandom; wdata = $urandom; size = 2'($urandom); uns = 1'($urandom);
        if (acc) begin
            cyc = 0;
            while (stall && cyc < TMO + 20) begin
                if (cyc == rst_busy) begin
                    rst_n = 0;
                    #1;
                    chk("req_after_reset", {31'b0, dbus_req}, 32'h0);
                    chk("stall_after_reset", {31'b0, stall}, 32'h0);
                    chk("fault_after_reset", {31'b0, fault}, 32'h0);
                    @(negedge clk);
                    rst_n = 1;
                    break;
                end
                trap = (cyc == trap_busy);
                stall_cnt++;
                cyc++;
                @(negedge clk);
            end
            trap = 0;
            if (rst_busy < 0) begin
                exp_stall = 1 + (tmo ? TMO + 1 : delay + 1);
                chk("stall_cycles", stall_cnt, exp_stall);
            end
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    // Bus responder: checks each new request against the expected queue and acks it.
    initial begin : responder
        bus_t cur;
        bit   active;
        int   k;
        active = 0;
        k = 0;
        dbus_ack = 0; dbus_err = 0; dbus_rdata = 0;
        forever begin
            @(negedge clk);
            dbus_ack = 0;
            dbus_err = 0;
            dbus_rdata = $urandom;
            if (dbus_req) begin
                if (!active) begin
                    if (bus_q.size() == 0) begin
                        chk("unexpected_bus_req", {31'b0, dbus_req}, 32'h0);
                    end else begin
                        cur = bus_q.pop_front();
                        active = 1;
                        k = 0;
                    end
                end else begin
                    k++;
                end
                if (active) begin
                    chk("dbus_we", {31'b0, dbus_we}, {31'b0, cur.we});
                    chk("dbus_addr", dbus_addr, cur.addr);
                    chk("dbus_mask", {28'b0, dbus_mask}, {28'b0, cur.mask});
                    if (cur.we) chk("dbus_wdata", dbus_wdata, cur.wdata);
                    if (k == cur.delay) begin
                        dbus_ack = 1;
                        dbus_err = cur.err;
                        dbus_rdata = cur.rdata;
                    end
                end
            end else begin
                active = 0;
            end
        end
    end

    // Result monitor: any load_valid/fault strobe must match the next expected result.
    initial begin : monitor
        res_t e;
        forever begin
            @(negedge clk);
            if (load_valid || fault) begin
                if (res_q.size() == 0) begin
                    chk("unexpected_result", {30'b0, load_valid, fault}, 32'h0);
                end else begin
                    e = res_q.pop_front();
                    chk("access_fault", {31'b0, fault}, {31'b0, e.fault});
                    chk("load_valid", {31'b0, load_valid}, {31'b0, ~e.fault});
                    if (!e.fault) chk("load_data", load_data, e.data);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int sz, dly, tb_i, tr;
        bit s, l, e;
        rst_n = 0;
        ld_req = 0; st_req = 0; size = 0; uns = 0; addr = 0; wdata = 0;
        mis_ld = 0; mis_st = 0; trap = 0;
        repeat (3) @(negedge clk);
        chk("reset_req", {31'b0, dbus_req}, 32'h0);
        chk("reset_stall", {31'b0, stall}, 32'h0);
        chk("reset_valid", {31'b0, load_valid}, 32'h0);
        chk("reset_fault", {31'b0, fault}, 32'h0);
        chk("reset_load_data", load_data, 32'h0);
        chk("reset_mask", {28'b0, dbus_mask}, 32'h0);
        rst_n = 1;
        @(negedge clk);

        // LW, zero-wait ack
        issue(1, 0, 2, 0, 32'h100, 32'h0, 0, 0, 0, 0, 0, 32'hDEADBEEF, -1, -1);
        // LB / LBU / LH extraction and extension
        issue(1, 0, 0, 0, 32'h103, 32'h0, 0, 0, 0, 0, 0, 32'h80112233, -1, -1);
        issue(1, 0, 0, 1, 32'h103, 32'h0, 0, 0, 0, 1, 0, 32'h80112233, -1, -1);
        issue(1, 0, 1, 0, 32'h102, 32'h0, 0, 0, 0, 2, 0, 32'h80112233, -1, -1);
        // SB / SH lane replication and strobes
        issue(0, 1, 0, 0, 32'h201, 32'h000000A5, 0, 0, 0, 0, 0, 32'h0, -1, -1);
        issue(0, 1, 1, 0, 32'h202, 32'h00001234, 0, 0, 0, 1, 0, 32'h0, -1, -1);
        issue(0, 1, 2, 0, 32'h204, 32'hCAFEF00D, 0, 0, 0, 0, 0, 32'h0, -1, -1);
        // misaligned and trapped requests are ignored
        issue(1, 0, 2, 0, 32'h101, 32'h0, 1, 0, 0, 0, 0, 32'h0, -1, -1);
        issue(0, 1, 1, 0, 32'h203, 32'h1, 0, 1, 0, 0, 0, 32'h0, -1, -1);
        issue(1, 0, 2, 0, 32'h108, 32'h0, 0, 0, 1, 0, 0, 32'h0, -1, -1);
        // timeout and bus error faults
        issue(1, 0, 2, 0, 32'h10C, 32'h0, 0, 0, 0, TMO + 50, 0, 32'h12345678, -1, -1);
        issue(1, 0, 2, 0, 32'h110, 32'h0, 0, 0, 0, 1, 1, 32'h12345678, -1, -1);
        issue(0, 1, 2, 0, 32'h114, 32'h55AA55AA, 0, 0, 0, TMO + 5, 0, 32'h0, -1, -1);
        // trap mid-BUSY kills the load, bus still completes
        issue(1, 0, 2, 0, 32'h118, 32'h0, 0, 0, 0, 4, 0, 32'h0BADF00D, 1, -1);
        // reset mid-BUSY, then a clean access
        issue(1, 0, 2, 0, 32'h11C, 32'h0, 0, 0, 0, 10, 0, 32'h0, -1, 3);
        issue(1, 0, 1, 1, 32'h122, 32'h0, 0, 0, 0, 0, 0, 32'hFEDC8765, -1, -1);

        for (int n = 0; n < 200; n++) begin
            s   = ($urandom % 2) == 1;
            l   = !s && (($urandom % 20) != 0);
            sz  = $urandom_range(0, 3);
            dly = $urandom_range(0, 4);
            e   = ($urandom % 10) == 0;
            tr  = (($urandom % 8) == 0) ? $urandom_range(0, dly) : -1;
            tb_i = (($urandom % 12) == 0) ? 1 : 0;
            issue(l, s, sz, 1'($urandom), $urandom, $urandom,
                  ($urandom % 10) == 0, ($urandom % 10) == 0, tb_i[0],
                  dly, e, $urandom, tr, -1);
        end

        repeat (4) @(negedge clk);
        chk("res_queue_drained", res_q.size(), 32'h0);
        chk("bus_queue_drained", bus_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
